rob_tag_allocator: RTL and testbench

- Dispatch-side allocator directly upstream of the single-instruction ROB.
- Hands out up to two consecutive ROB entry tags per cycle in circular order. These become the ROB's dispatch address and dispatch-valid inputs.
- Reclaims entries using the ROB's per-cycle commit count and tracks the free-entry count.
- Supports a full flush that squashes all uncommitted entries.

---
 rtl/rob_tag_allocator_pkg.sv | 11 +
 rtl/rob_tag_allocator_ptr_adv.sv | 15 +
 rtl/rob_tag_allocator.sv | 105 ++++++++++
 tb/tb_rob_tag_allocator.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/rob_tag_allocator_pkg.sv
// Shared ROB sizing constants, used identically by the tag allocator and the ROB.
//   ROB_NUM  : number of ROB entries (power of two)
//   ROB_SEL  : tag width, log2(ROB_NUM)
//   COMNUM_W : width of the per-cycle commit-count / request-count encoding
package rob_tag_allocator_pkg;

  localparam int unsigned ROB_NUM  = 64;
  localparam int unsigned ROB_SEL  = $clog2(ROB_NUM);
  localparam int unsigned COMNUM_W = 2;

endpackage

// File: rtl/rob_tag_allocator_ptr_adv.sv
// Modular ROB pointer adder: sum = (ptr + inc) mod ROB_NUM.
//   ptr : current pointer (ROB_SEL bits)
//   inc : increment, 0..2 (COMNUM_W bits)
//   sum : advanced pointer; wraps naturally because ROB_NUM is a power of two
module rob_ptr_adv
  import rob_tag_allocator_pkg::*;
(
  input  logic [ROB_SEL-1:0]  ptr,
  input  logic [COMNUM_W-1:0] inc,
  output logic [ROB_SEL-1:0]  sum
);

  assign sum = ptr + ROB_SEL'(inc);

endmodule

// File: rtl/rob_tag_allocator.sv
// Dispatch-side ROB tag allocator: grants up to two consecutive tags per cycle,
// reclaims entries from the ROB commit count, and supports a full flush.
//   clk_i, reset_i (async, active-low)
//   req_num_i     : tags requested (0..2, 3 treated as 0)
//   stall_i       : downstream stall, blocks any grant
//   comnum_i      : entries committed by the ROB this cycle
//   flush_i       : squash all uncommitted entries
//   dp1_o/dp1_addr_o, dp2_o/dp2_addr_o : combinational grant and tags
//   alloc_stall_o : request pending but not granted
//   free_cnt_o, commit_ptr_o, full_o, empty_o, err_o : status
module rob_tag_allocator
  import rob_tag_allocator_pkg::*;
(
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic [1:0]          req_num_i,
  input  logic                stall_i,
  input  logic [COMNUM_W-1:0] comnum_i,
  input  logic                flush_i,
  output logic                dp1_o,
  output logic [ROB_SEL-1:0]  dp1_addr_o,
  output logic                dp2_o,
  output logic [ROB_SEL-1:0]  dp2_addr_o,
  output logic                alloc_stall_o,
  output logic [ROB_SEL:0]    free_cnt_o,
  output logic [ROB_SEL-1:0]  commit_ptr_o,
  output logic                full_o,
  output logic                empty_o,
  output logic                err_o
);

  localparam int unsigned FW = ROB_SEL + 1;  // free count width
  localparam int unsigned CW = ROB_SEL + 2;  // headroom for free-count arithmetic

  logic [ROB_SEL-1:0] alloc_ptr, alloc_nxt, alloc_inc;
  logic [ROB_SEL-1:0] commit_ptr, commit_nxt, commit_inc;
  logic [FW-1:0]      free_cnt, free_nxt;
  logic               err, err_nxt;

  logic               req_legal;
  logic               grant;
  logic [1:0]         gnum;
  logic [CW-1:0]      occupied;
  logic [CW-1:0]      free_sum;
  logic               over_commit;

  // All-or-nothing grant against the registered free count (no commit bypass).
  assign req_legal = (req_num_i != 2'd3);
  assign grant     = !stall_i && !flush_i && req_legal && (FW'(req_num_i) <= free_cnt);
  assign gnum      = (grant && req_legal) ? req_num_i : 2'd0;

  assign dp1_o         = grant && (req_num_i == 2'd1 || req_num_i == 2'd2);
  assign dp2_o         = grant && (req_num_i == 2'd2);
  assign alloc_stall_o = (req_num_i == 2'd1 || req_num_i == 2'd2) && !grant;
  assign dp1_addr_o    = alloc_ptr;

  rob_ptr_adv u_alloc_adv  (.ptr(alloc_ptr),  .inc(gnum),     .sum(alloc_inc));
  rob_ptr_adv u_commit_adv (.ptr(commit_ptr), .inc(comnum_i), .sum(commit_inc));
  rob_ptr_adv u_dp2_adv    (.ptr(alloc_ptr),  .inc(2'd1),     .sum(dp2_addr_o));

  assign occupied    = CW'(ROB_NUM) - CW'(free_cnt);
  assign over_commit = CW'(comnum_i) > occupied;
  assign free_sum    = CW'(free_cnt) + CW'(comnum_i) - CW'(gnum);

  // Next-state: flush honours the same-cycle commit, then resyncs alloc to commit.
  always_comb begin
    alloc_nxt  = alloc_inc;
    commit_nxt = commit_inc;
    free_nxt   = FW'(free_sum);
    err_nxt    = err;
    if (flush_i) begin
      alloc_nxt = commit_inc;
      free_nxt  = FW'(ROB_NUM);
    end else if (over_commit) begin
      err_nxt  = 1'b1;
      free_nxt = FW'(ROB_NUM);
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      alloc_ptr  <= '0;
      commit_ptr <= '0;
      free_cnt   <= FW'(ROB_NUM);
      err        <= 1'b0;
    end else begin
      alloc_ptr  <= alloc_nxt;
      commit_ptr <= commit_nxt;
      free_cnt   <= free_nxt;
      err        <= err_nxt;
    end
  end

  assign free_cnt_o   = free_cnt;
  assign commit_ptr_o = commit_ptr;
  assign full_o       = (free_cnt == '0);
  assign empty_o      = (free_cnt == FW'(ROB_NUM));
  assign err_o        = err;

  // Occupancy seen through the pointers matches the free count; once an
  // over-commit has been flagged the pointers are no longer meaningful.
  inv_a: assert property (@(posedge clk_i) disable iff (!reset_i || err)
    ROB_SEL'(alloc_ptr - commit_ptr) == ROB_SEL'(FW'(ROB_NUM) - free_cnt));

endmodule

// File: tb/tb_rob_tag_allocator.sv
module tb_rob_tag_allocator;
  localparam int N = 64;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic [1:0] req_num_i;
  logic       stall_i;
  logic [1:0] comnum_i;
  logic       flush_i;
  logic       dp1_o, dp2_o, alloc_stall_o, full_o, empty_o, err_o;
  logic [5:0] dp1_addr_o, dp2_addr_o, commit_ptr_o;
  logic [6:0] free_cnt_o;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integer occupancy bookkeeping.
  int m_alloc, m_commit, m_free;
  bit m_err;
  int c_req, c_stall, c_com, c_flush;

  rob_tag_allocator dut (
    .clk_i(clk_i), .reset_i(reset_i), .req_num_i(req_num_i), .stall_i(stall_i),
    .comnum_i(comnum_i), .flush_i(flush_i), .dp1_o(dp1_o), .dp1_addr_o(dp1_addr_o),
    .dp2_o(dp2_o), .dp2_addr_o(dp2_addr_o), .alloc_stall_o(alloc_stall_o),
    .free_cnt_o(free_cnt_o), .commit_ptr_o(commit_ptr_o), .full_o(full_o),
    .empty_o(empty_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic bit m_grant();
    return (c_stall == 0) && (c_flush == 0) && (c_req <= 2) && (c_req <= m_free);
  endfunction

  task automatic drive(input int req, input int stall, input int com, input int flush);
    c_req = req; c_stall = stall; c_com = com; c_flush = flush;
    req_num_i = 2'(req); stall_i = 1'(stall); comnum_i = 2'(com); flush_i = 1'(flush);
    #1;
  endtask

  // Clock edge with model update from the currently driven inputs.
  task automatic tick();
    int g;
    @(posedge clk_i);
    g = (m_grant() && c_req <= 2) ? c_req : 0;
    if (c_flush != 0) begin
      m_commit = (m_commit + c_com) % N;
      m_alloc  = m_commit;
      m_free   = N;
    end else begin
      if (c_com > N - m_free) begin
        m_err  = 1'b1;
        m_free = N;
      end else begin
        m_free = m_free + c_com - g;
      end
      m_alloc  = (m_alloc + g) % N;
      m_commit = (m_commit + c_com) % N;
    end
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    reset_i = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b1;
    m_alloc = 0; m_commit = 0; m_free = N; m_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(0, 0, 0, 0);
    checks++; if (dp1_o !== 1'b0 || dp2_o !== 1'b0) begin errors++; $display("FAIL reset_dp got=%b%b exp=00", dp1_o, dp2_o); end
    checks++; if (alloc_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", alloc_stall_o); end
    checks++; if (free_cnt_o !== 7'd64) begin errors++; $display("FAIL reset_free got=%0d exp=64", free_cnt_o); end
    checks++; if (full_o !== 1'b0 || empty_o !== 1'b1) begin errors++; $display("FAIL reset_full_empty got=%b%b exp=01", full_o, empty_o); end
    checks++; if (err_o !== 1'b0 || commit_ptr_o !== 6'd0 || dp1_addr_o !== 6'd0) begin errors++; $display("FAIL reset_ptrs got err=%b cp=%0d ap=%0d exp 0/0/0", err_o, commit_ptr_o, dp1_addr_o); end
    // Mid-operation async reset discards state without a clock edge.
    drive(2, 0, 0, 0);
    repeat (3) tick();
    #2 reset_i = 1'b0;
    #1;
    checks++; if (free_cnt_o !== 7'd64 || dp1_addr_o !== 6'd0) begin errors++; $display("FAIL async_reset got free=%0d ap=%0d exp 64/0", free_cnt_o, dp1_addr_o); end
    @(negedge clk_i);
    reset_i = 1'b1;
    m_alloc = 0; m_commit = 0; m_free = N; m_err = 1'b0;
  endtask

  task automatic test_first_grant();
    do_reset();
    drive(2, 0, 0, 0);
    checks++; if (dp1_o !== 1'b1 || dp2_o !== 1'b1) begin errors++; $display("FAIL first_dp got=%b%b exp=11", dp1_o, dp2_o); end
    checks++; if (dp1_addr_o !== 6'd0 || dp2_addr_o !== 6'd1) begin errors++; $display("FAIL first_addr got=%0d,%0d exp=0,1", dp1_addr_o, dp2_addr_o); end
    tick();
    drive(0, 0, 0, 0);
    checks++; if (free_cnt_o !== 7'd62 || dp1_addr_o !== 6'd2) begin errors++; $display("FAIL first_next got free=%0d ap=%0d exp 62/2", free_cnt_o, dp1_addr_o); end
  endtask

  task automatic test_fill_full();
    do_reset();
    repeat (32) begin drive(2, 0, 0, 0); tick(); end
    drive(1, 0, 0, 0);
    checks++; if (free_cnt_o !== 7'd0 || full_o !== 1'b1) begin errors++; $display("FAIL fill_full got free=%0d full=%b exp 0/1", free_cnt_o, full_o); end
    checks++; if (alloc_stall_o !== 1'b1 || dp1_o !== 1'b0) begin errors++; $display("FAIL full_stall got stall=%b dp1=%b exp 1/0", alloc_stall_o, dp1_o); end
    tick();
    // Partial space: one free entry, request for two, commit one in the same cycle.
    drive(0, 0, 1, 0); tick();
    drive(2, 0, 1, 0);
    checks++; if (free_cnt_o !== 7'd1 || dp1_o !== 1'b0 || alloc_stall_o !== 1'b1) begin errors++; $display("FAIL partial_nogrant got free=%0d dp1=%b stall=%b exp 1/0/1", free_cnt_o, dp1_o, alloc_stall_o); end
    tick();
    drive(2, 0, 0, 0);
    checks++; if (free_cnt_o !== 7'd2 || dp1_o !== 1'b1 || dp2_o !== 1'b1) begin errors++; $display("FAIL partial_grant got free=%0d dp=%b%b exp 2/11", free_cnt_o, dp1_o, dp2_o); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (31) begin drive(2, 0, 0, 0); tick(); end
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 2, 0); tick();
    drive(2, 0, 0, 0);
    checks++; if (dp1_addr_o !== 6'd63 || dp2_addr_o !== 6'd0 || dp2_o !== 1'b1) begin errors++; $display("FAIL wrap_addr got=%0d,%0d dp2=%b exp 63,0,1", dp1_addr_o, dp2_addr_o, dp2_o); end
    tick();
    drive(0, 0, 0, 0);
    checks++; if (dp1_addr_o !== 6'd1) begin errors++; $display("FAIL wrap_next got=%0d exp=1", dp1_addr_o); end
  endtask

  task automatic test_flush();
    do_reset();
    repeat (10) begin drive(2, 0, 0, 0); tick(); end
    repeat (5) begin drive(0, 0, 2, 0); tick(); end
    drive(2, 0, 1, 1);
    checks++; if (dp1_o !== 1'b0 || dp2_o !== 1'b0 || dp1_addr_o !== 6'd20 || commit_ptr_o !== 6'd10) begin errors++; $display("FAIL flush_cycle got dp=%b%b ap=%0d cp=%0d exp 00/20/10", dp1_o, dp2_o, dp1_addr_o, commit_ptr_o); end
    tick();
    drive(0, 0, 0, 0);
    checks++; if (commit_ptr_o !== 6'd11 || dp1_addr_o !== 6'd11) begin errors++; $display("FAIL flush_ptrs got cp=%0d ap=%0d exp 11/11", commit_ptr_o, dp1_addr_o); end
    checks++; if (free_cnt_o !== 7'd64 || empty_o !== 1'b1) begin errors++; $display("FAIL flush_free got free=%0d empty=%b exp 64/1", free_cnt_o, empty_o); end
  endtask

  task automatic test_random();
    int occ, com;
    bit eg;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      occ = N - m_free;
      com = $urandom_range(0, (occ < 2) ? occ : 2);
      drive($urandom_range(0, 3), ($urandom_range(0, 4) == 0), com, ($urandom_range(0, 24) == 0));
      eg = m_grant();
      checks++;
      if (dp1_o !== (eg && c_req >= 1 && c_req <= 2) || dp2_o !== (eg && c_req == 2) ||
          alloc_stall_o !== ((c_req == 1 || c_req == 2) && !eg)) begin
        errors++; $display("FAIL rand_grant cyc=%0d got dp=%b%b st=%b req=%0d free=%0d", i, dp1_o, dp2_o, alloc_stall_o, c_req, m_free);
      end
      checks++;
      if (dp1_addr_o !== 6'(m_alloc) || dp2_addr_o !== 6'((m_alloc + 1) % N) || commit_ptr_o !== 6'(m_commit)) begin
        errors++; $display("FAIL rand_ptrs cyc=%0d got ap=%0d a2=%0d cp=%0d exp %0d/%0d/%0d", i, dp1_addr_o, dp2_addr_o, commit_ptr_o, m_alloc, (m_alloc + 1) % N, m_commit);
      end
      checks++;
      if (free_cnt_o !== 7'(m_free) || full_o !== (m_free == 0) || empty_o !== (m_free == N) || err_o !== m_err) begin
        errors++; $display("FAIL rand_status cyc=%0d got free=%0d f=%b e=%b err=%b exp free=%0d err=%b", i, free_cnt_o, full_o, empty_o, err_o, m_free, m_err);
      end
      tick();
    end
  endtask

  task automatic test_overcommit();
    do_reset();
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 0);
    checks++; if (err_o !== 1'b1 || free_cnt_o !== 7'd64 || commit_ptr_o !== 6'd1) begin errors++; $display("FAIL overcommit got err=%b free=%0d cp=%0d exp 1/64/1", err_o, free_cnt_o, commit_ptr_o); end
    drive(1, 0, 0, 1); tick();
    drive(0, 0, 0, 0); tick();
    checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", err_o); end
  endtask

  initial begin
    reset_i = 1'b0;
    drive(0, 0, 0, 0);
    @(negedge clk_i);
    test_reset();
    test_first_grant();
    test_fill_full();
    test_wrap();
    test_flush();
    test_random();
    test_overcommit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
